// File: rtl/huffman_coder_param_if.sv
// Avalon-MM slave bus of the Huffman coder, grouped as one interface.
//   chipselect : access qualifier; nothing happens unless it is high
//   address    : 0 = encode symbol, 1 = LUT write, 2 = finalize / FIFO pop,
//                3 = status / control
//   write/read : access strobes
//   writedata  : write data
//   readdata   : read data, combinational from the current address
//   empty_out  : output FIFO empty
//   full_out   : output FIFO count >= FIFO_DEPTH-1
interface huffman_coder_param_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        empty_out;
  logic        full_out;

  modport master (
    output chipselect, address, write, read, writedata,
    input  readdata, empty_out, full_out
  );

  modport slave (
    input  chipselect, address, write, read, writedata,
    output readdata, empty_out, full_out
  );
endinterface

// File: rtl/huffman_coder_param.sv
// Table-driven Huffman encoder with an Avalon-MM register interface.
// Symbols written to address 0 are looked up in a code/length LUT and their
// codes are packed MSB-first into OUT_W-bit words, which queue in a
// show-ahead output FIFO read back through address 2.
//   clock  : single clock, all state on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : Avalon-MM slave (see huffman_coder_param_if)
module huffman_coder_param #(
  parameter int SYM_W      = 6,
  parameter int CODE_W     = 8,
  parameter int LEN_W      = 4,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  huffman_coder_param_if.slave  bus
);

  localparam int ACC_W  = OUT_W + CODE_W;
  localparam int PEND_W = $clog2(ACC_W + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int LUT_D  = 1 << SYM_W;
  localparam int ENT_W  = CODE_W + LEN_W;
  localparam logic [ACC_W-1:0] ONE       = 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] NEAR_FULL = CNT_W'(FIFO_DEPTH - 1);

  // Bus decode
  logic enc_wr, lut_wr, fin_wr, ctl_wr, pop_rd, flag_clr, soft_clr;
  assign enc_wr   = bus.chipselect && bus.write && (bus.address == 2'd0);
  assign lut_wr   = bus.chipselect && bus.write && (bus.address == 2'd1);
  assign fin_wr   = bus.chipselect && bus.write && (bus.address == 2'd2);
  assign ctl_wr   = bus.chipselect && bus.write && (bus.address == 2'd3);
  assign pop_rd   = bus.chipselect && bus.read  && (bus.address == 2'd2);
  assign flag_clr = ctl_wr && bus.writedata[0];
  assign soft_clr = ctl_wr && bus.writedata[1];

  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // LUT entry is {code, len}, the same layout as the writedata field above
  // the symbol index, so a LUT write stores that slice verbatim. The read
  // port is registered; a LUT write in the same cycle as an encode of the
  // same entry leaves the encode with the old contents.
  logic [ENT_W-1:0] lut_mem [LUT_D];
  logic [ENT_W-1:0] lut_rd_q;
  logic [CODE_W-1:0] lut_code;
  logic [LEN_W-1:0]  lut_len;

  always_ff @(posedge clock) begin
    if (lut_wr) lut_mem[bus.writedata[SYM_W-1:0]] <= bus.writedata[SYM_W+ENT_W-1:SYM_W];
    if (enc_wr) lut_rd_q <= lut_mem[bus.writedata[SYM_W-1:0]];
  end

  assign lut_code = lut_rd_q[ENT_W-1:LEN_W];
  assign lut_len  = lut_rd_q[LEN_W-1:0];

  // State
  logic              s1_valid_q, s1_valid_d;  // stage holds a symbol or token
  logic              s1_fin_q, s1_fin_d;      // stage holds the finalize token
  logic [ACC_W-1:0]  acc_q, acc_d;            // left-aligned pending bits
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PEND_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, err_q, err_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic              push_req, fifo_we, pop, len_ok;
  logic [OUT_W-1:0]  push_word;
  logic [ACC_W-1:0]  code_ext, mask, appended;
  int                sum;

  assign len_ok = (lut_len != '0) && (int'(lut_len) <= CODE_W);

  always_comb begin
    acc_d      = acc_q;
    pend_d     = pend_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    err_d      = err_q;
    s1_valid_d = enc_wr || fin_wr;
    s1_fin_d   = fin_wr;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    push_req   = 1'b0;
    push_word  = '0;
    code_ext   = '0;
    code_ext[CODE_W-1:0] = lut_code;
    mask       = (ONE << lut_len) - ONE;
    sum        = int'(pend_q) + int'(lut_len);
    // New bits land directly below the pending ones; only meaningful when
    // len_ok, otherwise the shift result is discarded.
    appended   = acc_q | ((code_ext & mask) << (ACC_W - sum));

    if (s1_valid_q) begin
      if (s1_fin_q) begin
        last_d = pend_q;
        if (pend_q != '0) begin
          // Bits below the pending ones are already zero: that is the pad.
          push_req  = 1'b1;
          push_word = acc_q[ACC_W-1 -: OUT_W];
          acc_d     = '0;
          pend_d    = '0;
        end
      end else if (!len_ok) begin
        err_d = 1'b1;
      end else if (sum >= OUT_W) begin
        push_req  = 1'b1;
        push_word = appended[ACC_W-1 -: OUT_W];
        acc_d     = appended << OUT_W;
        pend_d    = PEND_W'(sum - OUT_W);
      end else begin
        acc_d  = appended;
        pend_d = PEND_W'(sum);
      end
    end

    pop = pop_rd && (cnt_q != '0);
    if (pop_rd && (cnt_q == '0)) udf_d = 1'b1;

    // A pop on the same edge frees the slot the push needs.
    fifo_we = push_req && !soft_clr && ((cnt_q != FULL_CNT) || pop);
    if (push_req && !soft_clr && !fifo_we) ovf_d = 1'b1;

    if (fifo_we) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (fifo_we && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!fifo_we && pop) cnt_d = cnt_q - CNT_W'(1);

    if (flag_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
      err_d = 1'b0;
    end
    if (soft_clr) begin
      acc_d      = '0;
      pend_d     = '0;
      s1_valid_d = 1'b0;
      s1_fin_d   = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_fin_q   <= 1'b0;
      acc_q      <= '0;
      pend_q     <= '0;
      last_q     <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fin_q   <= s1_fin_d;
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_we) fifo_mem[wr_ptr_q] <= push_word;
  end

  // Read mux
  logic [31:0] status;
  always_comb begin
    status        = '0;
    status[7:0]   = 8'(pend_q);
    status[15:8]  = 8'(cnt_q);
    status[23:16] = 8'(last_q);
    status[24]    = ovf_q;
    status[25]    = udf_q;
    status[26]    = err_q;
    status[27]    = s1_valid_q;
    case (bus.address)
      2'd2:    bus.readdata = (cnt_q != '0) ? 32'(fifo_mem[rd_ptr_q]) : 32'd0;
      2'd3:    bus.readdata = status;
      default: bus.readdata = 32'd0;
    endcase
  end

  assign bus.empty_out = (cnt_q == '0);
  assign bus.full_out  = (cnt_q >= NEAR_FULL);

endmodule

// File: doc/huffman_coder_param.md
HUFFMAN_CODER_PARAM -- requirements
Module: huffman_coder_param

Interface
REQ-001 SHALL have parameter SYM_W, default 6: symbol index width (LUT depth 2^SYM_W).
REQ-002 SHALL have parameter CODE_W, default 8: maximum code length in bits.
REQ-003 SHALL have parameter LEN_W, default 4: code-length field width.
REQ-004 SHALL have parameter OUT_W, default 32: packed output word width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8: output FIFO depth in words, power of 2.
REQ-006 SHALL have port clock, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port chipselect, input, 1: Avalon-MM select.
REQ-009 SHALL have port address, input, 2: register select.
REQ-010 SHALL have port write, input, 1: Avalon-MM write strobe.
REQ-011 SHALL have port read, input, 1: Avalon-MM read strobe.
REQ-012 SHALL have port writedata, input, 32: write data.
REQ-013 SHALL have port readdata, output, 32: read data, combinational from current address.
REQ-014 SHALL have port empty_out, output, 1: output FIFO empty.
REQ-015 SHALL have port full_out, output, 1: FIFO count >= FIFO_DEPTH-1.

Function
REQ-016 SHALL treat an access as valid only when chipselect is high; reads have no side effects except at address 2.
REQ-017 SHALL, on a write to address 1, store {code = writedata[SYM_W+LEN_W+CODE_W-1:SYM_W+LEN_W], len = writedata[SYM_W+LEN_W-1:SYM_W]} at LUT entry writedata[SYM_W-1:0].
REQ-018 SHALL, on a write to address 0, enqueue symbol writedata[SYM_W-1:0]. Pipeline: cycle 1 registers the symbol and issues a synchronous LUT read; cycle 2 packs the code. One symbol per cycle is sustained.
REQ-019 SHALL append the low len bits of code MSB-first after the pending bits of an accumulator of width OUT_W+CODE_W, left-aligned.
REQ-020 SHALL push the top OUT_W bits to the FIFO and retain the remainder when pending bits >= OUT_W; at most one push per symbol (CODE_W <= OUT_W).
REQ-021 SHALL set sticky err_len, append no bits, and leave the accumulator unchanged for a symbol whose len is 0 or exceeds CODE_W.
REQ-022 SHALL, on a write to address 2 (finalize), send a token through the same pipeline so it is ordered after all in-flight symbols.
REQ-023 SHALL, when the finalize token is processed with pending bits > 0, zero-pad, push one word, latch last_bits = pending count, and clear the accumulator.
REQ-024 SHALL, when the finalize token is processed with 0 pending bits, push nothing and set last_bits = 0.
REQ-025 SHALL, when a push finds the FIFO full, drop the word and set sticky ovf; the accumulator still advances.
REQ-026 SHALL present the FIFO head word (show-ahead) on a read of address 2 and pop on that edge.
REQ-027 SHALL return 0 with no pop for a read of address 2 while the FIFO is empty, and set sticky udf.
REQ-028 SHALL, on a same-cycle push and pop, leave the FIFO count unchanged; a push into a full FIFO that coincides with a pop SHALL succeed.
REQ-029 SHALL return status on a read of address 3: [7:0] pending bits, [15:8] FIFO count, [23:16] last_bits, [24] ovf, [25] udf, [26] err_len, [27] busy (pipeline non-empty).
REQ-030 SHALL, on a write to address 3 with writedata[0]=1, clear ovf/udf/err_len, and with writedata[1]=1, soft-clear the accumulator, pipeline and FIFO; the LUT is kept.
REQ-031 SHALL apply a LUT write only to symbols whose address-0 write occurs in a later cycle.
REQ-032 SHALL give the encode write priority when both a LUT write and an encode read of the same entry fall in one cycle: the encode uses old data.

Reset
REQ-033 SHALL, on resetn low, immediately clear accumulator, pipeline, FIFO pointers/count, last_bits and all sticky flags. empty_out=1, full_out=0, readdata at address 2 = 0. LUT contents are undefined.
REQ-034 SHALL discard in-flight symbols and any finalize token on reset mid-operation; no word is pushed after release.

Verification
REQ-035 SHALL cover: LUT[5]={code 0b101, len 3}, write symbol 5 eleven times -> one word 0xB6DB6DB6, pending=1; finalize -> 0x80000000, last_bits=1.
REQ-036 SHALL cover: finalize with 0 pending -> FIFO count unchanged, last_bits=0.
REQ-037 SHALL cover: LUT[0].len=0, write symbol 0 -> err_len=1, pending unchanged; write addr3=0x1 -> err_len=0.
REQ-038 SHALL cover: fill FIFO to FIFO_DEPTH with len-8 codes (4 symbols/word), push a 9th word -> ovf=1, count=8; pop and push in the same cycle -> count=8, ovf set by that push only if no pop.
REQ-039 SHALL cover: read addr2 while empty -> readdata=0, udf=1, count=0.
REQ-040 SHALL cover: resetn low during back-to-back symbol writes -> after release status=0, empty_out=1.
